// File: rtl/inference_scheduler.sv
// Per-image inference scheduler: core clear, sorter launch, per-class spike counting, early
// stop on threshold, drain window and lowest-index argmax. Optional watchdog: SCHED_TIMEOUT_EN.
module inference_scheduler #(
  parameter int unsigned NUM_CLASSES     = 10,
  parameter int unsigned CLASS_BITS      = $clog2(NUM_CLASSES),
  parameter int unsigned SPIKE_THRESHOLD = 8,
  parameter int unsigned CNT_BITS        = $clog2(SPIKE_THRESHOLD + 1),
  parameter int unsigned DRAIN_CYCLES    = 64,
  parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  CORE_RESET_REQ,
  input  logic                  CORE_RESET_ACK,
  output logic                  NEW_IMAGE,
  input  logic                  IMAGE_ENCODED,
  output logic                  INFERENCE_DONE,
  input  logic                  OUT_SPIKE_VALID,
  input  logic [CLASS_BITS-1:0] OUT_SPIKE_ID,
  output logic                  RESULT_VALID,
  output logic [CLASS_BITS-1:0] RESULT_CLASS,
  output logic                  RESULT_TIMEOUT
);

  localparam int unsigned DrainBits = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned ThrM1I    = SPIKE_THRESHOLD - 1;
  localparam int unsigned LastIdxI  = NUM_CLASSES - 1;

  localparam logic [CLASS_BITS:0]   NumCls  = NUM_CLASSES[CLASS_BITS:0];
  localparam logic [CNT_BITS-1:0]   Thr     = SPIKE_THRESHOLD[CNT_BITS-1:0];
  localparam logic [CNT_BITS-1:0]   ThrM1   = ThrM1I[CNT_BITS-1:0];
  localparam logic [CLASS_BITS-1:0] LastIdx = LastIdxI[CLASS_BITS-1:0];
  localparam logic [DrainBits-1:0]  DrainLd = DRAIN_CYCLES[DrainBits-1:0];

  typedef enum logic [3:0] {
    StIdle, StClear, StLaunch, StArm, StRun, StStop, StDrain, StSelect, StDone
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q [NUM_CLASSES];
  logic [CNT_BITS-1:0]   cnt_d [NUM_CLASSES];
  logic [DrainBits-1:0]  drain_q, drain_d;
  logic [CLASS_BITS-1:0] sel_idx_q, sel_idx_d;
  logic [CLASS_BITS-1:0] best_idx_q, best_idx_d;
  logic [CNT_BITS-1:0]   best_cnt_q, best_cnt_d;
  logic                  win_q, win_d;
  logic                  tmo_q, tmo_d;
  logic [CLASS_BITS-1:0] res_class_q, res_class_d;
  logic                  res_timeout_q, res_timeout_d;
  logic                  busy_q, core_reset_req_q, new_image_q, inference_done_q, result_valid_q;

  logic                  spike_ok, spike_hit, wd_expired;
  logic [CNT_BITS-1:0]   spike_cnt, sel_cnt;

  assign spike_ok  = OUT_SPIKE_VALID && ({1'b0, OUT_SPIKE_ID} < NumCls) &&
                     (state_q inside {StArm, StRun, StDrain});
  assign spike_cnt = cnt_q[OUT_SPIKE_ID];
  // Only one spike per cycle, so at most one class can hit threshold at a time.
  assign spike_hit = spike_ok && (spike_cnt == ThrM1);
  assign sel_cnt   = cnt_q[sel_idx_q];

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned WdBits   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WdLastI  = TIMEOUT_CYCLES - 1;
  localparam logic [WdBits-1:0] WdLast = WdLastI[WdBits-1:0];

  logic [WdBits-1:0] wd_q, wd_d;

  assign wd_expired = (wd_q == WdLast);

  always_comb begin
    wd_d = wd_q;
    if (state_q == StLaunch) begin
      wd_d = '0;
    end else if (state_q inside {StArm, StRun}) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    drain_d       = drain_q;
    sel_idx_d     = sel_idx_q;
    best_idx_d    = best_idx_q;
    best_cnt_d    = best_cnt_q;
    win_d         = win_q;
    tmo_d         = tmo_q;
    res_class_d   = res_class_q;
    res_timeout_d = res_timeout_q;

    if (spike_ok && (spike_cnt != Thr)) begin
      cnt_d[OUT_SPIKE_ID] = spike_cnt + 1'b1;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (START) begin
          state_d       = StClear;
          res_class_d   = '0;
          res_timeout_d = 1'b0;
        end
      end
      StClear: begin
        for (int i = 0; i < NUM_CLASSES; i++) begin
          cnt_d[i] = '0;
        end
        if (CORE_RESET_ACK && IMAGE_ENCODED) begin
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        state_d = StArm;
        win_d   = 1'b0;
        tmo_d   = 1'b0;
      end
      StArm, StRun: begin
        if (spike_hit) begin
          state_d     = StStop;
          win_d       = 1'b1;
          res_class_d = OUT_SPIKE_ID;
        end else if (wd_expired) begin
          state_d = StStop;
          tmo_d   = 1'b1;
        end else if ((state_q == StArm) && !IMAGE_ENCODED) begin
          state_d = StRun;
        end else if ((state_q == StRun) && IMAGE_ENCODED) begin
          state_d = StDrain;
          drain_d = DrainLd;
        end
      end
      StStop: begin
        if (IMAGE_ENCODED) begin
          if (win_q) begin
            state_d = StDone;
          end else begin
            state_d    = StSelect;
            sel_idx_d  = '0;
            best_idx_d = '0;
            best_cnt_d = '0;
          end
        end
      end
      StDrain: begin
        // Sorter is already idle here, so a late winner skips STOP entirely.
        if (spike_hit) begin
          state_d       = StDone;
          res_class_d   = OUT_SPIKE_ID;
          res_timeout_d = 1'b0;
        end else if (drain_q == DrainBits'(1)) begin
          state_d    = StSelect;
          sel_idx_d  = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      StSelect: begin
        // Strictly-greater replacement keeps ties on the lowest index.
        if (sel_cnt > best_cnt_q) begin
          best_cnt_d = sel_cnt;
          best_idx_d = sel_idx_q;
        end
        if (sel_idx_q == LastIdx) begin
          state_d       = StDone;
          res_class_d   = (best_cnt_d == '0) ? '0 : best_idx_d;
          res_timeout_d = (best_cnt_d == '0) || tmo_q;
        end else begin
          sel_idx_d = sel_idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q          <= StIdle;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt_q[i] <= '0;
      end
      drain_q          <= '0;
      sel_idx_q        <= '0;
      best_idx_q       <= '0;
      best_cnt_q       <= '0;
      win_q            <= 1'b0;
      tmo_q            <= 1'b0;
      res_class_q      <= '0;
      res_timeout_q    <= 1'b0;
      busy_q           <= 1'b0;
      core_reset_req_q <= 1'b0;
      new_image_q      <= 1'b0;
      inference_done_q <= 1'b0;
      result_valid_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      drain_q          <= drain_d;
      sel_idx_q        <= sel_idx_d;
      best_idx_q       <= best_idx_d;
      best_cnt_q       <= best_cnt_d;
      win_q            <= win_d;
      tmo_q            <= tmo_d;
      res_class_q      <= res_class_d;
      res_timeout_q    <= res_timeout_d;
      // Outputs registered from next state so they track state_q exactly.
      busy_q           <= (state_d != StIdle) && (state_d != StDone);
      core_reset_req_q <= (state_d == StClear);
      new_image_q      <= (state_d == StLaunch);
      inference_done_q <= (state_d == StStop);
      result_valid_q   <= (state_d == StDone);
    end
  end

  assign BUSY           = busy_q;
  assign CORE_RESET_REQ = core_reset_req_q;
  assign NEW_IMAGE      = new_image_q;
  assign INFERENCE_DONE = inference_done_q;
  assign RESULT_VALID   = result_valid_q;
  assign RESULT_CLASS   = res_class_q;
  assign RESULT_TIMEOUT = res_timeout_q;

endmodule

// File: tb/tb_inference_scheduler.sv
// Scoreboard bench for inference_scheduler: random and directed images checked against a
// per-class spike-count model; the watchdog case runs only when SCHED_TIMEOUT_EN is defined.
module tb_inference_scheduler;

  localparam int NumCls = 10;
  localparam int Thr    = 8;
  localparam int Drain  = 64;
  localparam int Cb     = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b1;
  logic          START = 1'b0;
  logic          BUSY;
  logic          CORE_RESET_REQ;
  logic          CORE_RESET_ACK = 1'b0;
  logic          NEW_IMAGE;
  logic          IMAGE_ENCODED = 1'b1;
  logic          INFERENCE_DONE;
  logic          OUT_SPIKE_VALID = 1'b0;
  logic [Cb-1:0] OUT_SPIKE_ID = '0;
  logic          RESULT_VALID;
  logic [Cb-1:0] RESULT_CLASS;
  logic          RESULT_TIMEOUT;

  inference_scheduler #(.TIMEOUT_CYCLES(100)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .START          (START),
    .BUSY           (BUSY),
    .CORE_RESET_REQ (CORE_RESET_REQ),
    .CORE_RESET_ACK (CORE_RESET_ACK),
    .NEW_IMAGE      (NEW_IMAGE),
    .IMAGE_ENCODED  (IMAGE_ENCODED),
    .INFERENCE_DONE (INFERENCE_DONE),
    .OUT_SPIKE_VALID(OUT_SPIKE_VALID),
    .OUT_SPIKE_ID   (OUT_SPIKE_ID),
    .RESULT_VALID   (RESULT_VALID),
    .RESULT_CLASS   (RESULT_CLASS),
    .RESULT_TIMEOUT (RESULT_TIMEOUT)
  );

  initial forever #5 CLK = ~CLK;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         rise_cyc = 0;
  bit         idone_seen = 1'b0;
  logic [4:0] exp_q[$];   // {timeout, class}
  int         dir_q[$];   // directed spike IDs, consumed before random stimulus
  int         mcnt[NumCls];
  bit         won;
  int         winner;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Monitor: compares every fresh RESULT_VALID against the oldest expected result.
  initial begin
    bit rv_prev = 1'b0;
    logic [4:0] e;
    forever begin
      @(negedge CLK);
      if (INFERENCE_DONE) idone_seen = 1'b1;
      if (RESULT_VALID && !rv_prev) begin
        rise_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("result_class", int'(RESULT_CLASS), int'(e[3:0]));
          chk("result_timeout", int'(RESULT_TIMEOUT), int'(e[4]));
        end
      end
      rv_prev = RESULT_VALID;
    end
  end

  // Reference: count valid in-range spikes per class; first to reach Thr wins.
  task automatic gen_spike(input int prob);
    bit v;
    int id;
    if (dir_q.size() > 0) begin
      v  = 1'b1;
      id = dir_q.pop_front();
    end else begin
      v  = ($urandom_range(0, 99) < prob);
      id = $urandom_range(0, 15);
    end
    OUT_SPIKE_VALID = v;
    OUT_SPIKE_ID    = id[Cb-1:0];
    if (v && id < NumCls && !won) begin
      if (mcnt[id] < Thr) mcnt[id]++;
      if (mcnt[id] == Thr) begin
        won    = 1'b1;
        winner = id;
      end
    end
  endtask

  function automatic logic [4:0] model_select();
    int best = 0;
    int idx = 0;
    for (int i = 0; i < NumCls; i++) begin
      if (mcnt[i] > best) begin
        best = mcnt[i];
        idx  = i;
      end
    end
    return (best == 0) ? 5'b10000 : {1'b0, 4'(idx)};
  endfunction

  task automatic wait_result();
    bit got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge CLK);
      got = RESULT_VALID;
    end
    if (!got) chk("result_wait", int'(got), 1);
    @(negedge CLK);
  endtask

  task automatic start_pulse();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("clear_req", int'(CORE_RESET_REQ), 1);
    chk("valid_drop", int'(RESULT_VALID), 0);
    chk("class_clear", int'(RESULT_CLASS), 0);
    chk("busy_clear", int'(BUSY), 1);
  endtask

  task automatic run_image(input int run_len, input int vprob, input int dvprob,
                           input int ack_delay, input bit start_in_run, input bit chk_lat);
    int c0;
    for (int i = 0; i < NumCls; i++) mcnt[i] = 0;
    won = 1'b0;
    IMAGE_ENCODED  = 1'b1;
    CORE_RESET_ACK = (ack_delay == 0);
    start_pulse();
    idone_seen = 1'b0;
    for (int k = 0; k < ack_delay; k++) begin
      @(negedge CLK);
      chk("no_launch_before_ack", int'(NEW_IMAGE), 0);
    end
    CORE_RESET_ACK = 1'b1;
    @(negedge CLK);
    chk("new_image", int'(NEW_IMAGE), 1);
    IMAGE_ENCODED = 1'b0;
    @(negedge CLK);
    chk("new_image_pulse", int'(NEW_IMAGE), 0);
    for (int i = 0; i < run_len && !won; i++) begin
      if (start_in_run && i == 2) START = 1'b1;
      gen_spike(vprob);
      @(negedge CLK);
      if (start_in_run && i == 2) begin
        START = 1'b0;
        chk("start_in_run_busy", int'(BUSY), 1);
        chk("start_in_run_noclr", int'(CORE_RESET_REQ), 0);
      end
    end
    OUT_SPIKE_VALID = 1'b0;
    if (won) begin
      chk("idone_rise", int'(INFERENCE_DONE), 1);
      repeat ($urandom_range(1, 4)) @(negedge CLK);
      chk("idone_held", int'(INFERENCE_DONE), 1);
      chk("held_no_result", int'(RESULT_VALID), 0);
      IMAGE_ENCODED = 1'b1;
      exp_q.push_back({1'b0, 4'(winner)});
      wait_result();
    end else begin
      IMAGE_ENCODED = 1'b1;
      c0 = cyc;
      for (int j = 0; j < Drain + 1 && !won; j++) begin
        gen_spike(dvprob);
        if (won) exp_q.push_back({1'b0, 4'(winner)});
        @(negedge CLK);
      end
      OUT_SPIKE_VALID = 1'b0;
      if (!won) exp_q.push_back(model_select());
      wait_result();
      if (chk_lat) chk("drain_select_latency", rise_cyc - c0, Drain + NumCls + 1);
      chk("no_idone", int'(idone_seen), 0);
    end
  endtask

  initial begin
    #2 RST_N = 1'b0;
    #1;
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_valid", int'(RESULT_VALID), 0);
    chk("rst_clr", int'(CORE_RESET_REQ), 0);
    chk("rst_newimg", int'(NEW_IMAGE), 0);
    chk("rst_idone", int'(INFERENCE_DONE), 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("idle_busy", int'(BUSY), 0);

    // Early win on class 3.
    repeat (8) dir_q.push_back(3);
    run_image(20, 0, 0, 0, 1'b0, 1'b0);

    // Drain and select with a tie between 2 and 5; ID 12 ignored.
    dir_q = '{2, 5, 12, 2, 7, 12, 5, 12, 2, 5, 12};
    run_image(11, 0, 0, 0, 1'b0, 1'b1);

    // No spikes at all.
    run_image(3, 0, 0, 0, 1'b0, 1'b0);

    // START ignored while running; launch follows a late ACK by one cycle.
    run_image(10, 30, 0, 3, 1'b1, 1'b0);

    // Asynchronous reset mid-run with class 1 already ahead.
    IMAGE_ENCODED  = 1'b1;
    CORE_RESET_ACK = 1'b1;
    start_pulse();
    @(negedge CLK);
    IMAGE_ENCODED = 1'b0;
    for (int i = 0; i < 5; i++) begin
      OUT_SPIKE_VALID = 1'b1;
      OUT_SPIKE_ID    = 4'd1;
      @(negedge CLK);
    end
    OUT_SPIKE_VALID = 1'b0;
    chk("pre_reset_busy", int'(BUSY), 1);
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_busy", int'(BUSY), 0);
    chk("async_rst_idone", int'(INFERENCE_DONE), 0);
    chk("async_rst_valid", int'(RESULT_VALID), 0);
    IMAGE_ENCODED = 1'b1;
    @(negedge CLK);
    RST_N = 1'b1;
    dir_q = '{6, 6};
    run_image(2, 0, 0, 0, 1'b0, 1'b0);

`ifdef SCHED_TIMEOUT_EN
    begin
      int c0;
      bit seen = 1'b0;
      IMAGE_ENCODED  = 1'b1;
      CORE_RESET_ACK = 1'b1;
      start_pulse();
      @(negedge CLK);
      c0 = cyc;
      IMAGE_ENCODED = 1'b0;
      @(negedge CLK);
      OUT_SPIKE_VALID = 1'b1;
      OUT_SPIKE_ID    = 4'd4;
      @(negedge CLK);
      OUT_SPIKE_VALID = 1'b0;
      for (int k = 0; k < 300 && !seen; k++) begin
        @(negedge CLK);
        seen = INFERENCE_DONE;
      end
      chk("wd_idone_seen", int'(seen), 1);
      chk("wd_latency", cyc - c0, 101);
      IMAGE_ENCODED = 1'b1;
      exp_q.push_back({1'b1, 4'd4});
      wait_result();
    end
`endif

    for (int n = 0; n < 30; n++) begin
      run_image($urandom_range(1, 40), $urandom_range(0, 70), $urandom_range(0, 30),
                $urandom_range(0, 2), 1'b0, 1'b0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/inference_scheduler.md
Name: inference_scheduler

Overview:
Per-image controller for the spike-encoding front end and SNN core. On a host START it clears the core, launches the sorter (NEW_IMAGE), and counts output-layer spikes per class. It stops the sorter early (INFERENCE_DONE) when a class reaches threshold. Otherwise it drains, then selects the class with the most spikes and presents a latched result to the host.

Parameters:
NUM_CLASSES, 10, number of output neurons/classes
CLASS_BITS, $clog2(NUM_CLASSES), class ID width
SPIKE_THRESHOLD, 8, spikes on one class that end inference early (>=1)
CNT_BITS, $clog2(SPIKE_THRESHOLD+1), per-class counter width
DRAIN_CYCLES, 64, cycles spikes are still counted after encoding finishes (>=1)
TIMEOUT_CYCLES, 65535, watchdog limit in ARM/RUN (used only with SCHED_TIMEOUT_EN)

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  host request for a new inference; single-cycle pulse
BUSY  out  1  high in every state except IDLE and DONE
CORE_RESET_REQ  out  1  held high in CLEAR; requests neuron-state clear
CORE_RESET_ACK  in  1  core has cleared its state
NEW_IMAGE  out  1  one-cycle launch pulse to the sorter
IMAGE_ENCODED  in  1  high while the sorter is idle
INFERENCE_DONE  out  1  abort request to the sorter, held in STOP
OUT_SPIKE_VALID  in  1  output-layer spike event
OUT_SPIKE_ID  in  CLASS_BITS  class of the spike
RESULT_VALID  out  1  high in DONE
RESULT_CLASS  out  CLASS_BITS  winning class
RESULT_TIMEOUT  out  1  no valid winner (zero spikes, or watchdog expired)

Behaviour:
- Reset: all outputs 0; state IDLE; counters, winner and flags cleared. Reset mid-operation aborts immediately; there is no recovery handshake.
- All outputs are Moore outputs decoded from registered state or registered result fields.
- IDLE: START -> CLEAR.
- CLEAR: CORE_RESET_REQ=1; class counters cleared. CORE_RESET_ACK && IMAGE_ENCODED -> LAUNCH.
- LAUNCH: NEW_IMAGE=1 for exactly one cycle -> ARM.
- Earliest START-to-NEW_IMAGE latency is 2 cycles (ACK already high).
- ARM: wait for IMAGE_ENCODED=0 -> RUN. Spikes are counted from ARM onward.
- Spike counting applies in ARM, RUN and DRAIN only:
  - OUT_SPIKE_ID >= NUM_CLASSES is ignored.
  - Counters saturate at SPIKE_THRESHOLD.
  - At most one spike per cycle, so only one class can reach threshold in a given cycle.
- RUN priority, highest first:
  - Spike taking a class to SPIKE_THRESHOLD: latch winner=ID, win flag -> STOP.
  - Watchdog expired -> STOP with timeout flag.
  - IMAGE_ENCODED=1 -> DRAIN.
- A threshold hit in ARM behaves exactly as in RUN.
- STOP: INFERENCE_DONE=1, spikes ignored; held until IMAGE_ENCODED=1. Then win flag -> DONE, else -> SELECT.
- DRAIN: down-counter loaded with DRAIN_CYCLES on entry; counting continues.
  - Threshold hit -> latch winner -> DONE (INFERENCE_DONE not asserted, sorter already idle).
  - Counter reaching 0 -> SELECT.
- SELECT: sequential scan, one class per cycle, index 0..NUM_CLASSES-1 (NUM_CLASSES cycles).
  - Best is replaced only on strictly greater count, so ties go to the lowest index.
  - End of scan -> DONE. If max count is 0: RESULT_CLASS=0, RESULT_TIMEOUT=1.
- DONE: RESULT_VALID=1; RESULT_* stable. START -> CLEAR; RESULT_VALID drops the next cycle and RESULT_* clear on CLEAR entry.
- START in any BUSY state is ignored and not queued.

Optional Feature:
SCHED_TIMEOUT_EN.
- Defined: a TIMEOUT_CYCLES watchdog counter, reset on ARM entry, increments every cycle in ARM and RUN. Expiry forces STOP with timeout flag; the result goes through SELECT with RESULT_TIMEOUT=1 and RESULT_CLASS = best class so far (0 if none).
- Undefined: no watchdog logic and TIMEOUT_CYCLES unused. ARM/RUN wait indefinitely; RESULT_TIMEOUT only flags the zero-spike case.

Test Plan:
1. Early win: START, ACK, encoding busy, 8 spikes ID=3 -> INFERENCE_DONE the cycle after the 8th spike, held until IMAGE_ENCODED=1; then RESULT_VALID=1, RESULT_CLASS=3, RESULT_TIMEOUT=0.
2. Drain and select: spikes ID2 x3, ID5 x3, ID7 x1, ID12 x4 (ignored), then IMAGE_ENCODED=1 -> RESULT_VALID exactly DRAIN_CYCLES+NUM_CLASSES+1 cycles later, RESULT_CLASS=2 (tie, lowest index).
3. No spikes: encoding completes -> RESULT_CLASS=0, RESULT_TIMEOUT=1, INFERENCE_DONE never asserted.
4. START pulse in RUN -> no effect; START in DONE -> RESULT_VALID=0 and CORE_RESET_REQ=1 next cycle; NEW_IMAGE one cycle after ACK.
5. RST_N low mid-RUN with counts non-zero -> all outputs 0 asynchronously; after release a fresh START gives a correct result unaffected by old counts.
6. SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=100, IMAGE_ENCODED held 0, one spike ID4 -> INFERENCE_DONE after 100 cycles in ARM/RUN; result RESULT_CLASS=4, RESULT_TIMEOUT=1.
